// File: rtl/resource_client_pkg.sv
// Shared types and constants for the resource client endpoint.
package resource_client_pkg;
  localparam int VALID_BUS_W     = 2;
  localparam int DEFAULT_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;
endpackage

// File: rtl/resource_client_resp_timer.sv
// Saturating response timer: clear, count-enable, terminal count at RESP_TIMEOUT.
module resp_timer #(
  parameter int RESP_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam int W = $clog2(RESP_TIMEOUT + 1);
  localparam logic [W-1:0] TC = W'(RESP_TIMEOUT);

  logic [W-1:0] count;

  // Holds at terminal count rather than wrapping back to zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != TC)) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == TC);
endmodule

// File: rtl/resource_client.sv
// Requester endpoint: captures one operand, requests the arbiter, issues on grant,
// waits for this client's result bit and holds it for the consumer.
module resource_client
  import resource_client_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CLIENT_ID    = 0,
  parameter int RESP_TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_flush,
  output logic                   arbiter_req,
  input  logic                   arbiter_grant,
  output logic [DATA_W-1:0]      resource_input,
  output logic                   out_valid_to_resource,
  input  logic [DATA_W-1:0]      resource_output,
  input  logic [VALID_BUS_W-1:0] in_valid_from_resource,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid_to_consumer,
  input  logic                   out_ready,
  output logic                   out_stall,
  output logic                   timeout_err
);
  state_t            state, next_state;
  logic [DATA_W-1:0] operand, result;
  logic              issue, tmo, capture_op, capture_res;
  logic              resp_hit, timer_done, timer_en;

  assign resp_hit = in_valid_from_resource[CLIENT_ID];
  assign timer_en = (state == ST_WAIT) || (state == ST_DRAIN);

  resp_timer #(.RESP_TIMEOUT(RESP_TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (issue),
    .enable (timer_en),
    .done   (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      operand <= '0;
      result  <= '0;
    end else begin
      state <= next_state;
      if (capture_op)  operand <= in_data;
      if (capture_res) result  <= resource_output;
    end
  end

  // Flush outranks grant, response and timeout everywhere except DRAIN.
  always_comb begin
    next_state  = state;
    issue       = 1'b0;
    tmo         = 1'b0;
    capture_op  = 1'b0;
    capture_res = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && !in_flush) begin
          capture_op = 1'b1;
          next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        if (in_flush) begin
          next_state = ST_IDLE;
        end else if (arbiter_grant) begin
          issue      = 1'b1;
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (in_flush) begin
          next_state = ST_DRAIN;
        end else if (resp_hit) begin
          capture_res = 1'b1;
          next_state  = ST_HOLD;
        end else if (timer_done) begin
          tmo        = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (resp_hit) begin
          next_state = ST_IDLE;
        end else if (timer_done) begin
          tmo        = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (in_flush || out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Every output is forced low while reset is held, not just after the edge.
  assign in_ready              = reset && (state == ST_IDLE);
  assign arbiter_req           = reset && (state == ST_REQ);
  assign out_valid_to_resource = reset && issue;
  assign resource_input        = reset ? operand : '0;
  assign out_data              = reset ? result : '0;
  assign out_valid_to_consumer = reset && (state == ST_HOLD);
  assign out_stall             = reset && in_valid && !in_ready;
  assign timeout_err           = reset && tmo;
endmodule

// File: doc/resource_client.md
Name: resource_client

Overview:
- Requester-side endpoint that a pipeline uses to reach the arbitrated shared resource.
- Accepts one operand from its upstream stage, raises an arbiter request and issues the operand when granted. Waits for the resource's per-client valid bit, then presents the result to the downstream consumer.
- One instance per pipeline; sits between the pipeline stage logic and the arbiter / shared_resource pair.

Parameters:
- DATA_W, 32, operand/result width.
- CLIENT_ID, 0, bit of the 2-bit resource valid bus owned by this client (0 or 1).
- RESP_TIMEOUT, 15, max cycles in WAIT before abandoning the transaction (>=1).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-low reset.
- in_data  in  DATA_W  operand from upstream.
- in_valid  in  1  operand valid.
- in_ready  out  1  client can accept an operand.
- in_flush  in  1  synchronous flush of the current transaction.
- arbiter_req  out  1  request to arbiter.
- arbiter_grant  in  1  grant from arbiter.
- resource_input  out  DATA_W  operand to shared resource.
- out_valid_to_resource  out  1  operand-valid strobe to resource.
- resource_output  in  DATA_W  result from resource.
- in_valid_from_resource  in  2  per-client result valid; only bit CLIENT_ID is used.
- out_data  out  DATA_W  result to consumer.
- out_valid_to_consumer  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_stall  out  1  equals in_valid & ~in_ready.
- timeout_err  out  1  one-cycle pulse on response timeout.

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE; operand, result and timer registers clear to 0.
  - All outputs are 0, including in_ready, for as long as reset is low.
  - Reset mid-transaction drops it silently.
- FSM states: IDLE, REQ, WAIT, DRAIN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid & ~in_flush: capture in_data, go to REQ.
- REQ:
  - arbiter_req=1 (registered; first asserted the cycle after capture).
  - resource_input = captured operand in all states.
  - arbiter_grant==1 in REQ: out_valid_to_resource=1 combinationally that cycle, timer clears, go to WAIT.
  - Grant observed outside REQ is ignored.
- WAIT:
  - arbiter_req=0; timer increments each cycle.
  - in_valid_from_resource[CLIENT_ID]==1: capture resource_output into out_data, go to HOLD.
  - The other bit is ignored.
  - Timer==RESP_TIMEOUT without a response: timeout_err pulses, go to IDLE.
  - Response and timeout in the same cycle: the response wins.
- DRAIN (entered by flush in WAIT):
  - The next response for this client is discarded; then go to IDLE.
  - Timeout still applies, pulses timeout_err, then IDLE.
- HOLD:
  - out_valid_to_consumer=1; out_data stable until accepted.
  - out_ready: go to IDLE.
  - The next operand can be captured no earlier than the following cycle, so throughput is at most 1 per 4 cycles.
- Flush (in_flush==1, priority below reset, above everything else):
  - IDLE: the operand is not captured.
  - REQ: drop the request, go to IDLE; no issue, even if grant is high.
  - WAIT: go to DRAIN.
  - HOLD: drop the result, go to IDLE.
  - DRAIN: no effect.
- Latency: capture to earliest arbiter_req is 1 cycle; grant to result is the resource latency; result to consumer is 1 cycle.
- Timer width: $clog2(RESP_TIMEOUT+1); saturates, never wraps.

Decomposition:
- Package resource_client_pkg: state enum, valid-bus width constant (2), default timeout constant.
- Sub-module resp_timer: clear, enable, terminal count, parameterised by RESP_TIMEOUT.

Test Plan:
- Basic transaction, CLIENT_ID=0: in_data=0x0000_00A5; grant 2 cycles after req; response valid=2'b01, data=0x0000_014A two cycles later -> one-cycle out_valid_to_resource with resource_input=0xA5; out_data=0x14A with out_valid_to_consumer=1 until out_ready.
- Wrong-bit filtering, CLIENT_ID=1: send valid=2'b01 and then 2'b10 -> only 2'b10 is captured; the earlier beat is ignored.
- Timeout, RESP_TIMEOUT=15: grant, never respond -> timeout_err pulses exactly once, 15 cycles after WAIT entry; in_ready=1 the next cycle.
- Flush in WAIT, then late response 0xDEAD -> no out_valid_to_consumer; returns to IDLE; next operand 0x1 completes normally.
- Flush in REQ on the same cycle as grant=1 -> out_valid_to_resource stays 0; arbiter_req=0 the next cycle.
- Reset low during HOLD with out_ready=0 -> next cycle all outputs 0; after reset high, in_ready=1 and there is no stale out_valid_to_consumer.
